// File: rtl/status_register_unit_if.sv
// Bus bundle between the pipeline and the NZCV status register unit.
// master = pipeline side (drives EXE/exception controls, reads flags),
// slave  = status register unit.
interface status_register_unit_if;
  logic       exe_valid;
  logic       s_en;
  logic       flush;
  logic       freeze;
  logic [3:0] alu_flags;
  logic [3:0] flag_mask;
  logic       exc_take;
  logic       exc_ret;
  logic       n, z, c, v;
  logic       n_fwd, z_fwd, c_fwd, v_fwd;
  logic       shadow_valid;
  logic [3:0] shadow_flags;

  modport master (
    output exe_valid, s_en, flush, freeze, alu_flags, flag_mask, exc_take, exc_ret,
    input  n, z, c, v, n_fwd, z_fwd, c_fwd, v_fwd, shadow_valid, shadow_flags
  );

  modport slave (
    input  exe_valid, s_en, flush, freeze, alu_flags, flag_mask, exc_take, exc_ret,
    output n, z, c, v, n_fwd, z_fwd, c_fwd, v_fwd, shadow_valid, shadow_flags
  );
endinterface

// File: rtl/status_register_unit.sv
// Architectural NZCV status register feeding the ID-stage condition check.
// Flags are packed {n,z,c,v}. A single shadow copy supports exception
// entry/return.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_NORMAL | no saved copy; exc_ret is ignored
//   ST_EXC    | shadow holds saved flags; exc_ret restores them
module status_register_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         FWD_EN      = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  status_register_unit_if.slave bus
);

  typedef enum logic {ST_NORMAL, ST_EXC} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_flags;
  logic [3:0] r_shadow;
  logic [3:0] w_flags_next;
  logic [3:0] w_shadow_next;
  logic [3:0] w_cand;
  logic [3:0] w_fwd;
  logic       w_upd;
  logic       w_restore;

  assign w_upd     = bus.exe_valid & bus.s_en & ~bus.flush & ~bus.freeze;
  assign w_cand    = (bus.alu_flags & bus.flag_mask) | (r_flags & ~bus.flag_mask);
  assign w_restore = bus.exc_ret & ~bus.freeze & (r_state == ST_EXC);

  // Next-flag selection: restore beats a same-cycle update; freeze holds.
  always_comb begin
    w_flags_next = r_flags;
    if (w_restore) begin
      w_flags_next = r_shadow;
    end else if (w_upd) begin
      w_flags_next = w_cand;
    end
  end

  // Exception FSM next state and shadow capture (shadow saves post-update value).
  always_comb begin
    w_state_next  = r_state;
    w_shadow_next = r_shadow;
    if (!bus.freeze) begin
      case (r_state)
        ST_NORMAL: begin
          if (bus.exc_take) begin
            w_shadow_next = w_flags_next;
            w_state_next  = ST_EXC;
          end
        end
        ST_EXC: begin
          if (bus.exc_take) begin
            w_shadow_next = w_flags_next;
          end else if (bus.exc_ret) begin
            w_state_next = ST_NORMAL;
          end
        end
        default: w_state_next = ST_NORMAL;
      endcase
    end
  end

  // State, flag and shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_NORMAL;
      r_flags  <= RESET_FLAGS;
      r_shadow <= 4'b0000;
    end else begin
      r_state  <= w_state_next;
      r_flags  <= w_flags_next;
      r_shadow <= w_shadow_next;
    end
  end

  // Forwarding lets the condition check see a same-cycle flag write.
  assign w_fwd = FWD_EN ? w_flags_next : r_flags;

  assign {bus.n, bus.z, bus.c, bus.v}                 = r_flags;
  assign {bus.n_fwd, bus.z_fwd, bus.c_fwd, bus.v_fwd} = w_fwd;
  assign bus.shadow_valid = (r_state == ST_EXC);
  assign bus.shadow_flags = r_shadow;

endmodule

// File: tb/tb_status_register_unit.sv
module tb_status_register_unit;

  typedef struct {
    logic       ev, s, fl, fz;
    logic [3:0] alu, mask;
    logic       take, ret;
    logic [3:0] efwd, eflg;
    logic       esv;
    logic [3:0] esh;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  vec_t vecs[$];

  status_register_unit_if sif();

  status_register_unit #(.RESET_FLAGS(4'b0000), .FWD_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic ev, s, fl, fz, input logic [3:0] alu, mask,
                     input logic take, ret, input logic [3:0] efwd, eflg,
                     input logic esv, input logic [3:0] esh);
    vec_t t;
    t.ev = ev; t.s = s; t.fl = fl; t.fz = fz; t.alu = alu; t.mask = mask;
    t.take = take; t.ret = ret; t.efwd = efwd; t.eflg = eflg; t.esv = esv; t.esh = esh;
    vecs.push_back(t);
  endtask

  task automatic idle();
    sif.exe_valid = 0; sif.s_en = 0; sif.flush = 0; sif.freeze = 0;
    sif.alu_flags = 4'b0000; sif.flag_mask = 4'b0000;
    sif.exc_take = 0; sif.exc_ret = 0;
  endtask

  function automatic logic [3:0] flags();
    return {sif.n, sif.z, sif.c, sif.v};
  endfunction

  function automatic logic [3:0] fwd();
    return {sif.n_fwd, sif.z_fwd, sif.c_fwd, sif.v_fwd};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rst = 1'b1;

    //  ev s fl fz  alu      mask     tk rt  fwd      flags    sv shadow
    add(1,1,0,0, 4'b0100, 4'b1111, 0,0, 4'b0100, 4'b0100, 0, 4'b0000); // 0 first write, z only
    add(1,1,0,0, 4'b1011, 4'b1111, 0,0, 4'b1011, 4'b1011, 0, 4'b0000); // 1
    add(1,1,0,0, 4'b0100, 4'b1100, 0,0, 4'b0111, 4'b0111, 0, 4'b0000); // 2 partial mask
    add(1,1,0,0, 4'b0010, 4'b1111, 0,0, 4'b0010, 4'b0010, 0, 4'b0000); // 3
    add(1,1,1,0, 4'b1111, 4'b1111, 0,0, 4'b0010, 4'b0010, 0, 4'b0000); // 4 flush
    add(1,1,0,1, 4'b1111, 4'b1111, 0,0, 4'b0010, 4'b0010, 0, 4'b0000); // 5 freeze
    add(1,1,0,1, 4'b1111, 4'b1111, 1,0, 4'b0010, 4'b0010, 0, 4'b0000); // 6 freeze blocks take
    add(1,0,0,0, 4'b1111, 4'b1111, 0,0, 4'b0010, 4'b0010, 0, 4'b0000); // 7 no S bit
    add(1,1,0,0, 4'b1000, 4'b1111, 0,0, 4'b1000, 4'b1000, 0, 4'b0000); // 8
    add(1,1,0,0, 4'b0001, 4'b1111, 1,0, 4'b0001, 4'b0001, 1, 4'b0001); // 9 take + upd
    add(1,1,0,0, 4'b0100, 4'b1111, 0,0, 4'b0100, 4'b0100, 1, 4'b0001); // 10
    add(0,0,0,0, 4'b0000, 4'b0000, 0,1, 4'b0001, 4'b0001, 0, 4'b0001); // 11 return
    add(1,1,0,0, 4'b0110, 4'b0011, 0,1, 4'b0010, 4'b0010, 0, 4'b0001); // 12 ret in NORMAL + upd
    add(0,0,0,0, 4'b0000, 4'b0000, 0,1, 4'b0010, 4'b0010, 0, 4'b0001); // 13 ret in NORMAL
    add(1,1,0,0, 4'b1010, 4'b1111, 0,0, 4'b1010, 4'b1010, 0, 4'b0001); // 14
    add(0,0,0,0, 4'b0000, 4'b0000, 1,0, 4'b1010, 4'b1010, 1, 4'b1010); // 15 take alone
    add(1,1,0,0, 4'b1111, 4'b1111, 0,0, 4'b1111, 4'b1111, 1, 4'b1010); // 16
    add(1,1,0,0, 4'b0101, 4'b1111, 0,1, 4'b1010, 4'b1010, 0, 4'b1010); // 17 ret beats upd
    add(1,1,0,0, 4'b1111, 4'b0000, 0,0, 4'b1010, 4'b1010, 0, 4'b1010); // 18 empty mask
    add(0,0,0,0, 4'b0000, 4'b0000, 1,0, 4'b1010, 4'b1010, 1, 4'b1010); // 19
    add(1,1,0,0, 4'b0011, 4'b1111, 1,0, 4'b0011, 4'b0011, 1, 4'b0011); // 20 nested take
    add(1,1,0,0, 4'b1100, 4'b1111, 0,0, 4'b1100, 4'b1100, 1, 4'b0011); // 21
    add(1,1,0,0, 4'b1111, 4'b1111, 1,1, 4'b0011, 4'b0011, 1, 4'b0011); // 22 take+ret+upd
    add(0,0,0,1, 4'b0000, 4'b0000, 0,1, 4'b0011, 4'b0011, 1, 4'b0011); // 23 freeze holds ret
    add(1,1,0,0, 4'b1111, 4'b1111, 0,0, 4'b1111, 4'b1111, 1, 4'b0011); // 24

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_flags", flags(), 4'b0000);
    check("reset_fwd", fwd(), 4'b0000);
    check("reset_sv", {3'b000, sif.shadow_valid}, 4'b0000);
    check("reset_shadow", sif.shadow_flags, 4'b0000);

    foreach (vecs[i]) begin
      @(negedge clk);
      sif.exe_valid = vecs[i].ev;  sif.s_en = vecs[i].s;
      sif.flush = vecs[i].fl;      sif.freeze = vecs[i].fz;
      sif.alu_flags = vecs[i].alu; sif.flag_mask = vecs[i].mask;
      sif.exc_take = vecs[i].take; sif.exc_ret = vecs[i].ret;
      #1;
      check($sformatf("v%0d_fwd", i), fwd(), vecs[i].efwd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_flags", i), flags(), vecs[i].eflg);
      check($sformatf("v%0d_sv", i), {3'b000, sif.shadow_valid}, {3'b000, vecs[i].esv});
      check($sformatf("v%0d_shadow", i), sif.shadow_flags, vecs[i].esh);
    end

    // In EXC with flags 1111: async reset between edges takes effect at once.
    @(negedge clk);
    idle();
    #2;
    check("pre_rst_flags", flags(), 4'b1111);
    check("pre_rst_sv", {3'b000, sif.shadow_valid}, 4'b0001);
    rst = 1'b1;
    #1;
    check("async_rst_flags", flags(), 4'b0000);
    check("async_rst_fwd", fwd(), 4'b0000);
    check("async_rst_sv", {3'b000, sif.shadow_valid}, 4'b0000);
    check("async_rst_shadow", sif.shadow_flags, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // After reset the FSM is NORMAL, so exc_ret must not restore anything.
    @(negedge clk);
    sif.exc_ret = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ret_flags", flags(), 4'b0000);
    check("post_rst_ret_sv", {3'b000, sif.shadow_valid}, 4'b0000);
    @(negedge clk);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
